// File: rtl/writeback_stage_pkg.sv
// Shared types for the writeback stage: word/register types, FSM state enum
// and load funct3 encodings.
package rvga_types;

    typedef logic [31:0] rvga_word;
    typedef logic [4:0]  rvga_reg;

    typedef enum logic {
        WB_IDLE      = 1'b0,
        WB_WAIT_LOAD = 1'b1
    } rvga_wb_state_e;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

endpackage

// File: rtl/writeback_stage_load_align.sv
// Combinational load formatter: picks the byte/half selected by addr_lo from the
// raw aligned word and sign- or zero-extends it according to funct3.
module load_align
    import rvga_types::*;
(
    input  rvga_word    data,
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    output rvga_word    word
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte = data[7:0];
        case (addr_lo)
            2'd0: sel_byte = data[7:0];
            2'd1: sel_byte = data[15:8];
            2'd2: sel_byte = data[23:16];
            2'd3: sel_byte = data[31:24];
            default: sel_byte = data[7:0];
        endcase
        // addr_lo[0] is deliberately ignored for halfword loads
        sel_half = addr_lo[1] ? data[31:16] : data[15:0];
    end

    always_comb begin
        word = data;
        case (funct3)
            F3_LB:   word = {{24{sel_byte[7]}}, sel_byte};
            F3_LBU:  word = {24'h0, sel_byte};
            F3_LH:   word = {{16{sel_half[15]}}, sel_half};
            F3_LHU:  word = {16'h0, sel_half};
            default: word = data;
        endcase
    end

endmodule

// File: rtl/writeback_stage.sv
// Writeback stage: forwards ALU results and formats load responses into the
// register file write port. Optional retire counter behind RVGA_RETIRE_CNT_EN.
//
// Handshake: an instruction transfers on a cycle where mem_writeback_v and
// mem_writeback_ready are both high at posedge clk; ready is a pure decode of
// the registered state, so it never depends combinationally on any input.
module writeback_stage
    import rvga_types::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            mem_writeback_v,
    output logic            mem_writeback_ready,
    input  rvga_reg         mem_writeback_rd,
    input  rvga_word        mem_writeback_rd_data,
    input  logic            mem_writeback_load_v,
    input  logic [2:0]      mem_writeback_funct3,
    input  logic [1:0]      mem_writeback_addr_lo,
    input  logic            dmem_writeback_resp_v,
    input  rvga_word        dmem_writeback_resp_data,
    output logic            writeback_rfetch_rd_w_v,
    output rvga_reg         writeback_rfetch_rd,
    output rvga_word        writeback_rfetch_rd_data,
`ifdef RVGA_RETIRE_CNT_EN
    output rvga_word        writeback_retire_cnt,
`endif
    output rvga_wb_state_e  wb_state
);

    rvga_wb_state_e state_q, state_d;
    rvga_reg        ld_rd_q;
    logic [2:0]     ld_funct3_q;
    logic [1:0]     ld_addr_lo_q;
    logic           w_v_q;
    rvga_reg        rd_q;
    rvga_word       rd_data_q;
    rvga_word       load_word;

    logic accept, alu_done, load_done, wb_done;

    load_align u_load_align (
        .data    (dmem_writeback_resp_data),
        .funct3  (ld_funct3_q),
        .addr_lo (ld_addr_lo_q),
        .word    (load_word)
    );

    always_comb begin
        state_d   = state_q;
        accept    = 1'b0;
        alu_done  = 1'b0;
        load_done = 1'b0;
        case (state_q)
            WB_IDLE: begin
                accept   = mem_writeback_v;
                alu_done = mem_writeback_v && !mem_writeback_load_v;
                if (mem_writeback_v && mem_writeback_load_v)
                    state_d = WB_WAIT_LOAD;
            end
            WB_WAIT_LOAD: begin
                load_done = dmem_writeback_resp_v;
                if (dmem_writeback_resp_v)
                    state_d = WB_IDLE;
            end
            default: state_d = WB_IDLE;
        endcase
        wb_done = alu_done || load_done;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= WB_IDLE;
            ld_rd_q      <= '0;
            ld_funct3_q  <= '0;
            ld_addr_lo_q <= '0;
            w_v_q        <= 1'b0;
            rd_q         <= '0;
            rd_data_q    <= '0;
        end else begin
            state_q <= state_d;
            w_v_q   <= 1'b0;
            if (accept && mem_writeback_load_v) begin
                ld_rd_q      <= mem_writeback_rd;
                ld_funct3_q  <= mem_writeback_funct3;
                ld_addr_lo_q <= mem_writeback_addr_lo;
            end
            // x0 writes still drive rd/data but never raise the enable
            if (alu_done) begin
                w_v_q     <= (mem_writeback_rd != '0);
                rd_q      <= mem_writeback_rd;
                rd_data_q <= mem_writeback_rd_data;
            end else if (load_done) begin
                w_v_q     <= (ld_rd_q != '0);
                rd_q      <= ld_rd_q;
                rd_data_q <= load_word;
            end
        end
    end

`ifdef RVGA_RETIRE_CNT_EN
    rvga_word retire_cnt_q;

    always_ff @(posedge clk) begin
        if (rst)
            retire_cnt_q <= '0;
        else if (wb_done)
            retire_cnt_q <= retire_cnt_q + 32'd1;
    end

    assign writeback_retire_cnt = retire_cnt_q;
`else
    logic unused_wb_done;
    assign unused_wb_done = wb_done;
`endif

    assign mem_writeback_ready      = (state_q == WB_IDLE);
    assign writeback_rfetch_rd_w_v  = w_v_q;
    assign writeback_rfetch_rd      = rd_q;
    assign writeback_rfetch_rd_data = rd_data_q;
    assign wb_state                 = state_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: vector table of ALU/load cases plus
// hand-written sequences for back-to-back accepts and reset during a load.
module tb_writeback_stage;
    import rvga_types::*;

    logic           clk = 1'b0;
    logic           rst;
    logic           mem_writeback_v;
    logic           mem_writeback_ready;
    rvga_reg        mem_writeback_rd;
    rvga_word       mem_writeback_rd_data;
    logic           mem_writeback_load_v;
    logic [2:0]     mem_writeback_funct3;
    logic [1:0]     mem_writeback_addr_lo;
    logic           dmem_writeback_resp_v;
    rvga_word       dmem_writeback_resp_data;
    logic           writeback_rfetch_rd_w_v;
    rvga_reg        writeback_rfetch_rd;
    rvga_word       writeback_rfetch_rd_data;
    rvga_wb_state_e wb_state;
`ifdef RVGA_RETIRE_CNT_EN
    rvga_word       writeback_retire_cnt;
    logic [31:0]    exp_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    writeback_stage dut (
        .clk                      (clk),
        .rst                      (rst),
        .mem_writeback_v          (mem_writeback_v),
        .mem_writeback_ready      (mem_writeback_ready),
        .mem_writeback_rd         (mem_writeback_rd),
        .mem_writeback_rd_data    (mem_writeback_rd_data),
        .mem_writeback_load_v     (mem_writeback_load_v),
        .mem_writeback_funct3     (mem_writeback_funct3),
        .mem_writeback_addr_lo    (mem_writeback_addr_lo),
        .dmem_writeback_resp_v    (dmem_writeback_resp_v),
        .dmem_writeback_resp_data (dmem_writeback_resp_data),
        .writeback_rfetch_rd_w_v  (writeback_rfetch_rd_w_v),
        .writeback_rfetch_rd      (writeback_rfetch_rd),
        .writeback_rfetch_rd_data (writeback_rfetch_rd_data),
`ifdef RVGA_RETIRE_CNT_EN
        .writeback_retire_cnt     (writeback_retire_cnt),
`endif
        .wb_state                 (wb_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic        load_v;
        logic [2:0]  funct3;
        logic [1:0]  addr_lo;
        logic [4:0]  rd;
        logic [31:0] data;
        logic [31:0] exp_data;
        logic        exp_w_v;
    } vec_t;

    vec_t vecs[15];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_writeback_v          = 1'b0;
        mem_writeback_rd         = '0;
        mem_writeback_rd_data    = '0;
        mem_writeback_load_v     = 1'b0;
        mem_writeback_funct3     = '0;
        mem_writeback_addr_lo    = '0;
        dmem_writeback_resp_v    = 1'b0;
        dmem_writeback_resp_data = '0;
    endtask

    task automatic check_cnt(input string name);
`ifdef RVGA_RETIRE_CNT_EN
        check(name, writeback_retire_cnt, exp_cnt);
`endif
    endtask

    task automatic bump_cnt();
`ifdef RVGA_RETIRE_CNT_EN
        exp_cnt = exp_cnt + 32'd1;
`endif
    endtask

    // driver: one table entry, either an ALU op or a load with a 3-cycle response delay
    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        mem_writeback_v       = 1'b1;
        mem_writeback_load_v  = v.load_v;
        mem_writeback_rd      = v.rd;
        mem_writeback_funct3  = v.funct3;
        mem_writeback_addr_lo = v.addr_lo;
        if (v.load_v) begin
            mem_writeback_rd_data = 32'h0BAD0BAD;
            // response in the acceptance cycle must be ignored
            dmem_writeback_resp_v    = 1'b1;
            dmem_writeback_resp_data = 32'h13579BDF;
            tick();
            mem_writeback_v       = 1'b0;
            dmem_writeback_resp_v = 1'b0;
            for (int k = 0; k < 3; k++) begin
                check($sformatf("v%0d wait ready", i), 32'(mem_writeback_ready), 32'd0);
                check($sformatf("v%0d wait w_v", i), 32'(writeback_rfetch_rd_w_v), 32'd0);
                if (k < 2) tick();
            end
            dmem_writeback_resp_v    = 1'b1;
            dmem_writeback_resp_data = v.data;
            tick();
            dmem_writeback_resp_v = 1'b0;
        end else begin
            mem_writeback_rd_data = v.data;
            tick();
            mem_writeback_v = 1'b0;
        end
        bump_cnt();
        check($sformatf("v%0d w_v", i), 32'(writeback_rfetch_rd_w_v), 32'(v.exp_w_v));
        check($sformatf("v%0d rd", i), 32'(writeback_rfetch_rd), 32'(v.rd));
        check($sformatf("v%0d data", i), writeback_rfetch_rd_data, v.exp_data);
        check($sformatf("v%0d ready", i), 32'(mem_writeback_ready), 32'd1);
        check_cnt($sformatf("v%0d cnt", i));
        // idle cycle: enable drops, rd/data hold
        idle_inputs();
        tick();
        check($sformatf("v%0d hold w_v", i), 32'(writeback_rfetch_rd_w_v), 32'd0);
        check($sformatf("v%0d hold rd", i), 32'(writeback_rfetch_rd), 32'(v.rd));
        check($sformatf("v%0d hold data", i), writeback_rfetch_rd_data, v.exp_data);
    endtask

    initial begin
        //          load  funct3   addr  rd     data          exp_data      w_v
        vecs[0]  = '{1'b0, 3'b000, 2'd0, 5'd5,  32'h12345678, 32'h12345678, 1'b1};
        vecs[1]  = '{1'b0, 3'b000, 2'd0, 5'd0,  32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[2]  = '{1'b1, 3'b000, 2'd2, 5'd3,  32'h80FF0000, 32'hFFFFFFFF, 1'b1};
        vecs[3]  = '{1'b1, 3'b100, 2'd2, 5'd3,  32'h80FF0000, 32'h000000FF, 1'b1};
        vecs[4]  = '{1'b1, 3'b001, 2'd2, 5'd7,  32'h80010000, 32'hFFFF8001, 1'b1};
        vecs[5]  = '{1'b1, 3'b101, 2'd2, 5'd7,  32'h80010000, 32'h00008001, 1'b1};
        vecs[6]  = '{1'b1, 3'b010, 2'd2, 5'd9,  32'h80010000, 32'h80010000, 1'b1};
        vecs[7]  = '{1'b1, 3'b000, 2'd0, 5'd4,  32'h1234567F, 32'h0000007F, 1'b1};
        vecs[8]  = '{1'b1, 3'b000, 2'd3, 5'd4,  32'h80FF0000, 32'hFFFFFF80, 1'b1};
        vecs[9]  = '{1'b1, 3'b001, 2'd3, 5'd6,  32'h7FFF1234, 32'h00007FFF, 1'b1};
        vecs[10] = '{1'b1, 3'b101, 2'd1, 5'd6,  32'hABCD8765, 32'h00008765, 1'b1};
        vecs[11] = '{1'b1, 3'b100, 2'd1, 5'd8,  32'hABCD8765, 32'h00000087, 1'b1};
        vecs[12] = '{1'b1, 3'b011, 2'd3, 5'd10, 32'hCAFEF00D, 32'hCAFEF00D, 1'b1};
        vecs[13] = '{1'b1, 3'b010, 2'd0, 5'd0,  32'h55AA55AA, 32'h55AA55AA, 1'b0};
        vecs[14] = '{1'b0, 3'b000, 2'd0, 5'd31, 32'h00000000, 32'h00000000, 1'b1};

        idle_inputs();
`ifdef RVGA_RETIRE_CNT_EN
        exp_cnt = 32'd0;
`endif
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;

        check("reset w_v", 32'(writeback_rfetch_rd_w_v), 32'd0);
        check("reset rd", 32'(writeback_rfetch_rd), 32'd0);
        check("reset data", writeback_rfetch_rd_data, 32'd0);
        check("reset ready", 32'(mem_writeback_ready), 32'd1);
        check("reset state", 32'(wb_state), 32'(WB_IDLE));
        check_cnt("reset cnt");

        // response while idle is ignored
        dmem_writeback_resp_v    = 1'b1;
        dmem_writeback_resp_data = 32'hFFFFFFFF;
        tick();
        dmem_writeback_resp_v = 1'b0;
        check("idle resp w_v", 32'(writeback_rfetch_rd_w_v), 32'd0);
        check("idle resp state", 32'(wb_state), 32'(WB_IDLE));
        check_cnt("idle resp cnt");

        for (int i = 0; i < 15; i++) run_vec(i);

        // back-to-back ALU accepts, counter preloaded to wrap
`ifdef RVGA_RETIRE_CNT_EN
        force dut.retire_cnt_q = 32'hFFFFFFFE;
        #1;
        release dut.retire_cnt_q;
        exp_cnt = 32'hFFFFFFFE;
`endif
        for (int i = 0; i < 4; i++) begin
            mem_writeback_v       = 1'b1;
            mem_writeback_load_v  = 1'b0;
            mem_writeback_rd      = 5'(i + 1);
            mem_writeback_rd_data = 32'hA0000000 + 32'(i);
            tick();
            bump_cnt();
            check($sformatf("b2b%0d w_v", i), 32'(writeback_rfetch_rd_w_v), 32'd1);
            check($sformatf("b2b%0d rd", i), 32'(writeback_rfetch_rd), 32'(i + 1));
            check($sformatf("b2b%0d data", i), writeback_rfetch_rd_data, 32'hA0000000 + 32'(i));
            check($sformatf("b2b%0d ready", i), 32'(mem_writeback_ready), 32'd1);
        end
        idle_inputs();
`ifdef RVGA_RETIRE_CNT_EN
        check("b2b wrap cnt", writeback_retire_cnt, 32'h00000002);
`endif
        tick();
        check("b2b end w_v", 32'(writeback_rfetch_rd_w_v), 32'd0);

        // reset while waiting for a load drops it
        mem_writeback_v       = 1'b1;
        mem_writeback_load_v  = 1'b1;
        mem_writeback_rd      = 5'd12;
        mem_writeback_funct3  = F3_LW;
        tick();
        idle_inputs();
        check("rstwait state", 32'(wb_state), 32'(WB_WAIT_LOAD));
        check("rstwait ready", 32'(mem_writeback_ready), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
`ifdef RVGA_RETIRE_CNT_EN
        exp_cnt = 32'd0;
`endif
        check("post rst state", 32'(wb_state), 32'(WB_IDLE));
        check("post rst ready", 32'(mem_writeback_ready), 32'd1);
        dmem_writeback_resp_v    = 1'b1;
        dmem_writeback_resp_data = 32'h77777777;
        tick();
        dmem_writeback_resp_v = 1'b0;
        check("late resp w_v", 32'(writeback_rfetch_rd_w_v), 32'd0);
        check("late resp rd", 32'(writeback_rfetch_rd), 32'd0);
        check("late resp data", writeback_rfetch_rd_data, 32'd0);
        check("late resp state", 32'(wb_state), 32'(WB_IDLE));
        check_cnt("late resp cnt");

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
